puzzle4_stream_ctrl: RTL and testbench

PUZZLE4_STREAM_CTRL -- requirements
Module: puzzle4_stream_ctrl

---
 rtl/puzzle4_stream_ctrl.sv | 172 +++++++++++++++++
 tb/tb_puzzle4_stream_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle4_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : puzzle4_stream_ctrl
//  Brief    : Fetches grid rows from a row memory and streams them MSB-word
//             first to a datapath, then flushes, drains and captures the sum.
//  Revision : 1.0 - initial release
// ============================================================================
module puzzle4_stream_ctrl #(
  parameter int ROW_SIZE     = 160,
  parameter int MODULAR_SIZE = 32,
  parameter int NUM_ROWS     = 139,
  parameter int ADDR_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int FLUSH_ROWS   = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    hold,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [ROW_SIZE-1:0]     mem_rdata,
  output logic [MODULAR_SIZE-1:0] word_out,
  output logic                    word_valid,
  input  logic [OUTPUT_WIDTH-1:0] sum_in,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    busy,
  output logic                    done
);

  localparam int c_WPR         = ROW_SIZE / MODULAR_SIZE;
  localparam int c_FLUSH_WORDS = FLUSH_ROWS * c_WPR;
  localparam int c_ROW_W       = $clog2(NUM_ROWS + 1);
  localparam int c_WORD_W      = $clog2(c_WPR + 1);
  localparam int c_FLUSH_W     = $clog2(c_FLUSH_WORDS + 1) + 1;
  localparam int c_DRAIN_W     = $clog2(DRAIN_CYCLES + 1) + 1;

  localparam logic [c_ROW_W-1:0]   c_LAST_ROW   = c_ROW_W'(NUM_ROWS - 1);
  localparam logic [c_WORD_W-1:0]  c_LAST_WORD  = c_WORD_W'(c_WPR - 1);
  localparam logic [c_FLUSH_W-1:0] c_LAST_FLUSH = c_FLUSH_W'(c_FLUSH_WORDS - 1);
  localparam logic [c_DRAIN_W-1:0] c_LAST_DRAIN = c_DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_PRIME  = 3'd2,
    S_STREAM = 3'd3,
    S_FLUSH  = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [c_ROW_W-1:0]      r_row;
  logic [c_WORD_W-1:0]     r_word;
  logic [c_FLUSH_W-1:0]    r_flush;
  logic [c_DRAIN_W-1:0]    r_drain;
  logic [ROW_SIZE-1:0]     r_row_buf;
  logic [ROW_SIZE-1:0]     r_next_buf;
  logic                    r_pf_pending;
  logic [OUTPUT_WIDTH-1:0] r_result;
  logic                    w_rd_en;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    w_valid;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    w_addr       = '0;
    w_valid      = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_FETCH;
      S_FETCH: begin
        w_rd_en      = 1'b1;
        w_next_state = S_PRIME;
      end
      S_PRIME: w_next_state = S_STREAM;
      S_STREAM: begin
        if (!hold) begin
          w_valid = 1'b1;
          // Prefetch the following row while the current one streams out
          if (r_word == '0 && r_row != c_LAST_ROW) begin
            w_rd_en = 1'b1;
            w_addr  = ADDR_WIDTH'(r_row + 1'b1);
          end
          if (r_word == c_LAST_WORD && r_row == c_LAST_ROW)
            w_next_state = (c_FLUSH_WORDS == 0) ? S_DRAIN : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!hold) begin
          w_valid = 1'b1;
          if (r_flush == c_LAST_FLUSH) w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: if (r_drain == c_LAST_DRAIN) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row        <= '0;
      r_word       <= '0;
      r_flush      <= '0;
      r_drain      <= '0;
      r_row_buf    <= '0;
      r_next_buf   <= '0;
      r_pf_pending <= 1'b0;
      r_result     <= '0;
    end else begin
      r_pf_pending <= (r_state == S_STREAM) && w_rd_en;
      if (r_pf_pending) r_next_buf <= mem_rdata;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row   <= '0;
            r_word  <= '0;
            r_flush <= '0;
            r_drain <= '0;
          end
        end
        S_PRIME: begin
          r_row_buf <= mem_rdata;
          r_word    <= '0;
        end
        S_STREAM: begin
          if (!hold) begin
            if (r_word == c_LAST_WORD) begin
              r_word <= '0;
              if (r_row != c_LAST_ROW) begin
                // With two words per row the prefetched data is still on mem_rdata
                r_row_buf <= r_pf_pending ? mem_rdata : r_next_buf;
                r_row     <= r_row + 1'b1;
              end else begin
                r_row_buf <= r_row_buf << MODULAR_SIZE;
              end
            end else begin
              r_row_buf <= r_row_buf << MODULAR_SIZE;
              r_word    <= r_word + 1'b1;
            end
          end
        end
        S_FLUSH: if (!hold) r_flush <= r_flush + 1'b1;
        S_DRAIN: begin
          r_drain <= r_drain + 1'b1;
          if (r_drain == c_LAST_DRAIN) r_result <= sum_in;
        end
        default: ;
      endcase
    end
  end

  // row_buf is fully shifted out after the last row, so flush words read as zero
  assign word_out   = r_row_buf[ROW_SIZE-1 -: MODULAR_SIZE];
  assign word_valid = w_valid;
  assign mem_rd_en  = w_rd_en;
  assign mem_addr   = w_addr;
  assign result     = r_result;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_puzzle4_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_puzzle4_stream_ctrl
//  Brief    : Directed bench for puzzle4_stream_ctrl (default and 64-bit rows).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_puzzle4_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, hold;
  logic         mem_rd_en;
  logic [7:0]   mem_addr;
  logic [159:0] mem_rdata;
  logic [31:0]  word_out;
  logic         word_valid;
  logic [15:0]  sum_in, result, acc;
  logic         busy, done, sum_const;

  logic         sm_start, sm_rd_en, sm_valid, sm_busy, sm_done;
  logic [7:0]   sm_addr;
  logic [63:0]  sm_rdata;
  logic [31:0]  sm_word_out;
  logic [15:0]  sm_sum_in, sm_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  puzzle4_stream_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .word_out(word_out), .word_valid(word_valid), .sum_in(sum_in),
    .result(result), .busy(busy), .done(done)
  );

  puzzle4_stream_ctrl #(.ROW_SIZE(64), .NUM_ROWS(3)) u_small (
    .clk(clk), .reset(reset), .start(sm_start), .hold(hold),
    .mem_rd_en(sm_rd_en), .mem_addr(sm_addr), .mem_rdata(sm_rdata),
    .word_out(sm_word_out), .word_valid(sm_valid), .sum_in(sm_sum_in),
    .result(sm_result), .busy(sm_busy), .done(sm_done)
  );

  localparam logic [63:0] ROW_A = 64'hA0A1A2A3_A4A5A6A7;
  localparam logic [63:0] ROW_B = 64'hB0B1B2B3_B4B5B6B7;
  localparam logic [63:0] ROW_C = 64'hC0C1C2C3_C4C5C6C7;

  // Word k (MSB first) of row r is {A5, k, r}
  function automatic logic [159:0] row_data(int r);
    logic [159:0] d;
    for (int k = 0; k < 5; k++) d[159-32*k -: 32] = {8'hA5, 8'(k), 16'(r)};
    return d;
  endfunction

  function automatic logic [31:0] exp_word(int i);
    int r = i / 5;
    int k = i % 5;
    if (r >= 139) return 32'h0;
    return {8'hA5, 8'(k), 16'(r)};
  endfunction

  function automatic logic [63:0] sm_row(int a);
    case (a)
      0: return ROW_A;
      1: return ROW_B;
      2: return ROW_C;
      default: return 64'h0;
    endcase
  endfunction

  // Row memories: garbage whenever no read was issued the cycle before
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? row_data(int'(mem_addr)) : {5{32'hDEADBEEF}};
    sm_rdata  <= sm_rd_en ? sm_row(int'(sm_addr)) : {2{32'hDEADBEEF}};
  end

  // Datapath model: running sum of the low half-word of every valid word
  always @(posedge clk) begin
    if (start) acc <= 16'h0;
    else if (word_valid) acc <= acc + word_out[15:0];
  end
  assign sum_in    = sum_const ? 16'h1234 : acc;
  assign sm_sum_in = 16'h0;

  int          cyc = 0;
  logic [31:0] words[$];
  int          vcyc[$];
  int          addrs[$];
  int          rd_cnt, addr_viol, done_cyc, done_cnt;
  logic [15:0] done_result;
  logic [31:0] sm_words[$];
  int          sm_vcyc[$];
  int          sm_done_cyc;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (word_valid) begin
      words.push_back(word_out);
      vcyc.push_back(cyc);
    end
    if (mem_rd_en) begin
      rd_cnt++;
      addrs.push_back(int'(mem_addr));
    end else if (mem_addr != 8'h0) begin
      addr_viol++;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
      done_result = result;
    end
    if (sm_valid) begin
      sm_words.push_back(sm_word_out);
      sm_vcyc.push_back(cyc);
    end
    if (sm_done) sm_done_cyc = cyc;
  end

  task automatic mon_clear();
    words.delete(); vcyc.delete(); addrs.delete();
    sm_words.delete(); sm_vcyc.delete();
    rd_cnt = 0; addr_viol = 0; done_cyc = -1; done_cnt = 0; sm_done_cyc = -1;
  endtask

  task automatic start_run(output int t0);
    @(negedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cyc < 0; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: done not seen within %0d cycles", limit);
    end
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 2000 && words.size() < n; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (words.size() != n) begin
      errors++;
      $display("FAIL wait_words: got %0d words, required %0d", words.size(), n);
    end
  endtask

  // Shared end-of-run checks for a full default run
  task automatic check_full_stream(input string tag, input int extra_gap);
    int bad = 0;
    int span;
    foreach (words[i]) if (words[i] !== exp_word(i)) bad++;
    checks++;
    if (words.size() != 700 || bad != 0) begin
      errors++;
      $display("FAIL %s_words: count %0d bad %0d, required count 700 bad 0", tag, words.size(), bad);
    end
    span = (vcyc.size() > 0) ? vcyc[vcyc.size()-1] - vcyc[0] : -1;
    checks++;
    if (span != 699 + extra_gap) begin
      errors++;
      $display("FAIL %s_span: got %0d, required %0d", tag, span, 699 + extra_gap);
    end
    bad = 0;
    foreach (addrs[i]) if (addrs[i] != i) bad++;
    checks++;
    if (rd_cnt != 139 || bad != 0 || addr_viol != 0) begin
      errors++;
      $display("FAIL %s_reads: pulses %0d badaddr %0d idleaddr %0d, required 139 0 0",
               tag, rd_cnt, bad, addr_viol);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; hold = 1'b0; sm_start = 1'b0; sum_const = 1'b0;
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, word_valid, mem_rd_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/valid/rd = %b, required 0000",
               {busy, done, word_valid, mem_rd_en});
    end
    checks++;
    if (word_out !== 32'h0 || mem_addr !== 8'h0 || result !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: word_out %h addr %h result %h, required 0",
               word_out, mem_addr, result);
    end
    start = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rd_cnt != 0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy %b reads %0d, required 0 0", busy, rd_cnt);
    end
  endtask

  task automatic test_full_run();
    int t0;
    mon_clear();
    start_run(t0);
    wait_done(1000);
    // start sampled at the edge after cycle t0: FETCH, PRIME, then STREAM seen at t0+3
    checks++;
    if (vcyc.size() == 0 || vcyc[0] != t0 + 3) begin
      errors++;
      $display("FAIL first_valid: got cycle %0d, required %0d",
               (vcyc.size() > 0) ? vcyc[0] : -1, t0 + 3);
    end
    check_full_stream("full", 0);
    checks++;
    if (vcyc.size() == 0 || done_cyc != vcyc[vcyc.size()-1] + 5) begin
      errors++;
      $display("FAIL done_latency: done at %0d, required last valid + 5", done_cyc);
    end
    checks++;
    if (done_result !== 16'hBB53 || result !== 16'hBB53) begin
      errors++;
      $display("FAIL full_result: got %h/%h, required bb53", done_result, result);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL full_idle: busy %b done %b pulses %0d, required 0 0 1", busy, done, done_cnt);
    end
  endtask

  task automatic test_small_rows();
    logic [31:0] exp_seq [8];
    int bad = 0;
    exp_seq = '{ROW_A[63:32], ROW_A[31:0], ROW_B[63:32], ROW_B[31:0],
                ROW_C[63:32], ROW_C[31:0], 32'h0, 32'h0};
    mon_clear();
    @(negedge clk); #1;
    sm_start = 1'b1;
    @(posedge clk); #1;
    sm_start = 1'b0;
    for (int i = 0; i < 100 && sm_done_cyc < 0; i++) begin
      @(negedge clk); #1;
    end
    foreach (sm_words[i]) if (i < 8 && sm_words[i] !== exp_seq[i]) bad++;
    checks++;
    if (sm_words.size() != 8 || bad != 0) begin
      errors++;
      $display("FAIL small_words: count %0d bad %0d, required 8 0", sm_words.size(), bad);
    end
    checks++;
    if (sm_vcyc.size() != 8 || sm_vcyc[7] - sm_vcyc[0] != 7 || sm_done_cyc < 0) begin
      errors++;
      $display("FAIL small_timing: count %0d done %0d, required 8 contiguous with done",
               sm_vcyc.size(), sm_done_cyc);
    end
  endtask

  task automatic hold_three(input int at_words, input int idx);
    wait_words(at_words);
    @(posedge clk); #1;
    hold = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (word_valid !== 1'b0 || word_out !== exp_word(idx)) begin
      errors++;
      $display("FAIL hold_freeze_%0d: valid %b word %h, required 0 %h",
               idx, word_valid, word_out, exp_word(idx));
    end
    repeat (3) @(posedge clk);
    #1;
    hold = 1'b0;
  endtask

  task automatic test_hold();
    int t0;
    mon_clear();
    start_run(t0);
    hold_three(54, 54);
    hold_three(697, 697);
    wait_done(1000);
    checks++;
    if (vcyc.size() < 700 || vcyc[54] - vcyc[53] != 4 || vcyc[697] - vcyc[696] != 4) begin
      errors++;
      $display("FAIL hold_gaps: stream gap/flush gap not 4 cycles (count %0d)", vcyc.size());
    end
    check_full_stream("hold", 6);
  endtask

  task automatic test_result_const();
    int t0;
    sum_const = 1'b1;
    mon_clear();
    start_run(t0);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1000);
    checks++;
    if (done_result !== 16'h1234) begin
      errors++;
      $display("FAIL const_result_done: got %h, required 1234", done_result);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h1234 || busy !== 1'b0 || done_cnt != 1 || rd_cnt != 139) begin
      errors++;
      $display("FAIL const_no_rerun: result %h busy %b pulses %0d reads %0d, required 1234 0 1 139",
               result, busy, done_cnt, rd_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int t0;
    mon_clear();
    start_run(t0);
    wait_words(250);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, word_valid, mem_rd_en} !== 4'b0000 || word_out !== 32'h0 ||
        mem_addr !== 8'h0 || result !== 16'h0) begin
      errors++;
      $display("FAIL midrun_reset: flags %b word %h addr %h result %h, required all 0",
               {busy, done, word_valid, mem_rd_en}, word_out, mem_addr, result);
    end
    reset = 1'b1;
    sum_const = 1'b0;
    mon_clear();
    start_run(t0);
    wait_done(1000);
    check_full_stream("rerun", 0);
    checks++;
    if (result !== 16'hBB53) begin
      errors++;
      $display("FAIL rerun_result: got %h, required bb53", result);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_small_rows();
    test_hold();
    test_result_const();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
